// File: rtl/seq_det_pkg.sv
// Shared types and the "1011" overlapping detector step function
// used by the multi-channel detector scheduler.
package seq_det_pkg;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } state_t;

    localparam logic [3:0] PATTERN = 4'b1011;

    typedef struct packed {
        state_t nxt;
        logic   match;
    } step_t;

    // One Mealy step; S3 plus the pattern's last bit completes a match
    // and falls back to S1 so the trailing 1 can start the next pattern.
    function automatic step_t next_state(input state_t s, input logic b);
        step_t r;
        r.nxt   = S0;
        r.match = 1'b0;
        unique case (s)
            S0: r.nxt = b ? S1 : S0;
            S1: r.nxt = b ? S1 : S2;
            S2: r.nxt = b ? S3 : S0;
            S3: begin
                r.nxt   = b ? S1 : S2;
                r.match = (b == PATTERN[0]);
            end
            default: r.nxt = S0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seq_det_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr,
// wrapping, wins a one-hot grant.
module rr_arbiter #(
    parameter int NCH = 4,
    parameter int CHW = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [CHW-1:0] ptr,
    output logic [NCH-1:0] gnt,
    output logic [CHW-1:0] idx,
    output logic           any_gnt
);

    always_comb begin
        int j;
        logic [CHW-1:0] jj;
        gnt     = '0;
        idx     = '0;
        any_gnt = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            j = int'(ptr) + k;
            if (j >= NCH) j = j - NCH;
            jj = CHW'(j);
            if (!any_gnt && req[jj]) begin
                any_gnt = 1'b1;
                idx     = jj;
                gnt[jj] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_det_sched.sv
// One shared "1011" detector time-multiplexed over NCH serial channels,
// with per-channel saved context and round-robin bit scheduling.
module seq_det_sched
    import seq_det_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int CHW  = $clog2(NCH),
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NCH-1:0]  req,
    input  logic [NCH-1:0]  din,
    input  logic [NCH-1:0]  clr,
    output logic [NCH-1:0]  gnt,
    output logic            match_vld,
    output logic [CHW-1:0]  match_ch,
    output logic [CNTW-1:0] match_cnt
);

    state_t         ctx   [NCH];
    state_t         ctx_d [NCH];
    logic [CHW-1:0] ptr, ptr_d;
    logic [CHW-1:0] idx;
    logic [NCH-1:0] arb_gnt;
    logic           any_gnt;
    logic           vld_d;
    logic [CHW-1:0] ch_d;
    logic [CNTW-1:0] cnt_d;
    step_t          st;

    rr_arbiter #(.NCH(NCH), .CHW(CHW)) u_arb (
        .req     (req),
        .ptr     (ptr),
        .gnt     (arb_gnt),
        .idx     (idx),
        .any_gnt (any_gnt)
    );

    assign gnt = rst ? '0 : arb_gnt;

    always_comb begin
        ctx_d = ctx;
        ptr_d = ptr;
        vld_d = 1'b0;
        ch_d  = match_ch;
        cnt_d = match_cnt;
        st    = next_state(ctx[idx], din[idx]);
        if (any_gnt) begin
            ptr_d = (idx == CHW'(NCH - 1)) ? '0 : idx + 1'b1;
            // A flush on the granted channel swallows its bit.
            if (!clr[idx]) begin
                ctx_d[idx] = st.nxt;
                if (st.match) begin
                    vld_d = 1'b1;
                    ch_d  = idx;
                    if (match_cnt != '1) cnt_d = match_cnt + 1'b1;
                end
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (clr[i]) ctx_d[i] = S0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) ctx[i] <= S0;
            ptr       <= '0;
            match_vld <= 1'b0;
            match_ch  <= '0;
            match_cnt <= '0;
        end else begin
            ctx       <= ctx_d;
            ptr       <= ptr_d;
            match_vld <= vld_d;
            match_ch  <= ch_d;
            match_cnt <= cnt_d;
        end
    end

endmodule
